// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the front-end pipeline registers: IF,
// the IF->ID buffer and ID. It detects load-use hazards, sequences
// branch-mispredict flushes and drains the back end before a syscall
// issues. It also keeps a saturating count of stalled cycles for
// performance debug.
//
// Parameters
//   FLUSH_CYCLES  cycles FLUSH_FE stays high per mispredict (1..7)
//   DRAIN_DEPTH   back-end stages drained before a syscall issues (1..7)
//   CNT_WIDTH     width of Stall_Count
//
// Ports
//   CLK            rising-edge clock
//   RESET          asynchronous, active-low reset
//   Mispredict_EX  EX resolved a branch against its prediction
//   Syscall_ID     instruction in ID is a syscall
//   ID_Rs/ID_Rt    ID source registers
//   ID_Uses_Rs/Rt  ID instruction actually reads rs / rt
//   EX_MemRead     EX instruction is a load
//   EX_Rd          EX destination register
//   IF_Miss        instruction fetch not ready this cycle
//   STALL_FE       hold IF, IF->ID buffer and ID
//   FLUSH_FE       clear IF->ID buffer and ID
//   Bubble_EX      load a NOP into EX instead of the ID output
//   State_OUT      FSM state (0 RUN, 1 FLUSH, 2 DRAIN, 3 SYSGO)
//   Stall_Count    cycles with STALL_FE=1, saturating at all-ones
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_DEPTH  = 3,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 Mispredict_EX,
  input  logic                 Syscall_ID,
  input  logic [4:0]           ID_Rs,
  input  logic [4:0]           ID_Rt,
  input  logic                 ID_Uses_Rs,
  input  logic                 ID_Uses_Rt,
  input  logic                 EX_MemRead,
  input  logic [4:0]           EX_Rd,
  input  logic                 IF_Miss,
  output logic                 STALL_FE,
  output logic                 FLUSH_FE,
  output logic                 Bubble_EX,
  output logic [1:0]           State_OUT,
  output logic [CNT_WIDTH-1:0] Stall_Count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SYSGO = 2'd3
  } state_t;

  localparam logic [2:0]           FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0]           DRAIN_RELOAD = 3'(DRAIN_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};

  state_t     state, state_nxt;
  // FLUSH and DRAIN are mutually exclusive, so one down-counter serves both.
  // It holds the number of further cycles to spend in the current state.
  logic [2:0] seq_cnt, seq_cnt_nxt;

  logic       load_use;
  logic       stall_c, flush_c, bubble_c;

  // Register 0 is hard-wired zero and can never be a load-use source.
  assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                    ((ID_Uses_Rs && (ID_Rs == EX_Rd)) ||
                     (ID_Uses_Rt && (ID_Rt == EX_Rd)));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    seq_cnt_nxt = seq_cnt;
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    bubble_c    = 1'b0;

    // A mispredict in EX belongs to an older instruction than anything in
    // the front end, so it overrides every state: it cancels a pending
    // syscall drain and restarts an ongoing flush. Flush also wins over
    // stall, so the two are never asserted together.
    if (Mispredict_EX) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt   = ST_FLUSH;
        seq_cnt_nxt = FLUSH_RELOAD;
      end else begin
        state_nxt   = ST_RUN;
        seq_cnt_nxt = 3'd0;
      end
    end else begin
      unique case (state)
        ST_RUN: begin
          if (Syscall_ID) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (DRAIN_DEPTH > 1) begin
              state_nxt   = ST_DRAIN;
              seq_cnt_nxt = DRAIN_RELOAD;
            end else begin
              state_nxt   = ST_SYSGO;
              seq_cnt_nxt = 3'd0;
            end
          end else if (load_use || IF_Miss) begin
            // Single-cycle hold; re-evaluated next cycle once the load moves on.
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (seq_cnt <= 3'd1) begin
            state_nxt   = ST_RUN;
            seq_cnt_nxt = 3'd0;
          end else begin
            seq_cnt_nxt = seq_cnt - 3'd1;
          end
        end
        ST_DRAIN: begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (seq_cnt <= 3'd1) begin
            state_nxt   = ST_SYSGO;
            seq_cnt_nxt = 3'd0;
          end else begin
            seq_cnt_nxt = seq_cnt - 3'd1;
          end
        end
        ST_SYSGO: begin
          // Back end is empty: let the syscall advance ID->EX untouched.
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt   = ST_RUN;
          seq_cnt_nxt = 3'd0;
        end
      endcase
    end
  end

  // Outputs are gated by RESET so an asserted reset silences the front-end
  // controls immediately, without waiting for a clock edge.
  assign STALL_FE  = RESET && stall_c;
  assign FLUSH_FE  = RESET && flush_c;
  assign Bubble_EX = RESET && bubble_c;
  assign State_OUT = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_RUN;
      seq_cnt     <= 3'd0;
      Stall_Count <= '0;
    end else begin
      state   <= state_nxt;
      seq_cnt <= seq_cnt_nxt;
      if (STALL_FE && (Stall_Count != CNT_MAX)) begin
        Stall_Count <= Stall_Count + 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the front-end pipeline registers: IF, the IF→ID buffer stage, and ID. It detects load-use hazards, sequences branch-mispredict flushes and drains the back end around syscalls. It drives the STALL and FLUSH inputs of those stages and injects bubbles into EX. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
FLUSH_CYCLES, 1, cycles FLUSH_FE stays asserted per mispredict (1..7)
DRAIN_DEPTH, 3, back-end stages (EX/MEM/WB) to drain before a syscall issues (1..7)
CNT_WIDTH, 32, width of Stall_Count

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
Mispredict_EX  input  1  EX resolved a branch against its prediction
Syscall_ID  input  1  instruction in ID is a syscall
ID_Rs  input  5  ID source register rs
ID_Rt  input  5  ID source register rt
ID_Uses_Rs  input  1  ID instruction reads rs
ID_Uses_Rt  input  1  ID instruction reads rt
EX_MemRead  input  1  EX instruction is a load
EX_Rd  input  5  EX destination register
IF_Miss  input  1  instruction fetch not ready this cycle
STALL_FE  output  1  stall IF, IF→ID buffer and ID (hold contents)
FLUSH_FE  output  1  clear IF→ID buffer and ID registers
Bubble_EX  output  1  load NOP into EX instead of ID output
State_OUT  output  2  FSM state (0 RUN, 1 FLUSH, 2 DRAIN, 3 SYSGO)
Stall_Count  output  CNT_WIDTH  cycles with STALL_FE=1, saturating

Behaviour:
- RESET low: state RUN, flush and drain counters 0, Stall_Count 0. STALL_FE, FLUSH_FE and Bubble_EX are forced 0 regardless of other inputs. Reset mid-sequence aborts it immediately.
- Outputs are combinational from the current state and current inputs. State and counters update on the rising CLK edge.
- Load-use hazard, in RUN only: LU = EX_MemRead && EX_Rd!=0 && ((ID_Uses_Rs && ID_Rs==EX_Rd) || (ID_Uses_Rt && ID_Rt==EX_Rd)). Register 0 never hazards.
- Priority in RUN: Mispredict_EX > Syscall_ID > LU > IF_Miss.
- RUN outputs:
  - Mispredict: FLUSH_FE=1, Bubble_EX=1, STALL_FE=0. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Syscall_ID (no mispredict): STALL_FE=1, Bubble_EX=1. Go to DRAIN with counter=DRAIN_DEPTH-1. If DRAIN_DEPTH=1, go directly to SYSGO.
  - LU: STALL_FE=1, Bubble_EX=1 for exactly this cycle. No state change; LU clears once the load leaves EX.
  - IF_Miss alone: STALL_FE=1, Bubble_EX=1.
- FLUSH: FLUSH_FE=1, Bubble_EX=1, STALL_FE=0. Decrement the counter; at 0 return to RUN. Syscall_ID and LU are ignored here. A new Mispredict_EX reloads the counter to FLUSH_CYCLES-1.
- DRAIN: STALL_FE=1, Bubble_EX=1. Decrement the counter; at 0 go to SYSGO. Mispredict_EX here (an older branch) overrides: FLUSH_FE=1, STALL_FE=0, and load FLUSH exactly as from RUN, which drops the pending syscall.
- SYSGO: all outputs 0 for one cycle so the syscall advances ID→EX, then RUN. Syscall_ID is not re-detected in SYSGO. Mispredict_EX here behaves as in RUN.
- FLUSH_FE and STALL_FE are never both 1. Flush wins.
- Stall_Count increments on every edge where STALL_FE=1 and saturates at all-ones, never wrapping.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs=5, ID_Uses_Rs=1 for one cycle → STALL_FE=1 and Bubble_EX=1 for 1 cycle, State_OUT=0, Stall_Count 0→1. The same stimulus with EX_Rd=0 → no stall.
- Mispredict with FLUSH_CYCLES=2: Mispredict_EX pulse at cycle t → FLUSH_FE=1 in cycles t and t+1, State_OUT=1 at t+1, RUN at t+2. STALL_FE=0 throughout.
- Syscall with DRAIN_DEPTH=3: Syscall_ID held high → STALL_FE=1 for cycles t..t+2 (DRAIN at t+1, t+2), SYSGO at t+3 with all outputs 0, RUN at t+4. Stall_Count=3.
- Mispredict at t+1 during DRAIN → FLUSH_FE=1, STALL_FE=0 at t+1, then RUN (FLUSH_CYCLES=1). SYSGO is never entered.
- Simultaneous Mispredict_EX, Syscall_ID and LU in RUN → only the flush response. LU re-evaluated the next cycle.
- Saturation and reset: CNT_WIDTH=4, hold IF_Miss for 20 cycles → Stall_Count stops at 15. Drop RESET mid-DRAIN → outputs 0 immediately, State_OUT=0, Stall_Count=0.
